// File: rtl/axi_pkg.sv
// Shared AXI3 constants, FSM state types and address helper for the SRAM responder.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } r_state_e;

    // Unaligned start addresses are treated as aligned to the bus width.
    function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                               input int unsigned nbytes);
        return addr & ~(nbytes - 1);
    endfunction

endpackage

// File: rtl/axi_ifc.sv
// AXI3 bundle (AW/W/B/AR/R) with a slave-side modport.
interface axi_ifc #(
    parameter int unsigned IWIDTH = 6,
    parameter int unsigned DWIDTH = 64
);
    logic [IWIDTH-1:0]   awid;
    logic [31:0]         awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DWIDTH-1:0]   wdata;
    logic [DWIDTH/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [IWIDTH-1:0]   bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [IWIDTH-1:0]   arid;
    logic [31:0]         araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [IWIDTH-1:0]   rid;
    logic [DWIDTH-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/sram_dp_bytewe.sv
// Simple dual-port RAM: byte-enabled write port, registered read port, read-first.
module sram_dp_bytewe #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic                     clk,
    input  logic [DWIDTH/8-1:0]      we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DWIDTH-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DWIDTH-1:0]        rdata
);
    localparam int unsigned NB = DWIDTH / 8;

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NB; b++) begin
            if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI3 slave backed by dual-port RAM; independent read and write FSMs, one burst each.
module axi_sram_responder
    import axi_pkg::*;
#(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned IWIDTH = 6,
    parameter int unsigned DEPTH  = 4096,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input logic   clk,
    input logic   rstn,
    axi_ifc.slave s
);
    localparam int unsigned NB = DWIDTH / 8;
    localparam int unsigned AL = $clog2(NB);
    localparam int unsigned AW = $clog2(DEPTH);

    // Keeps all ready/valid outputs low while rstn is asserted.
    logic alive;
    always_ff @(posedge clk) alive <= rstn;

    // ---------------- write channel ----------------
    w_state_e          w_state;
    logic [IWIDTH-1:0] w_id;
    logic [31:0]       w_addr, w_off;
    logic [3:0]        w_len;
    logic [1:0]        w_burst;
    logic [4:0]        w_cnt;
    logic              w_err, w_hs, w_at_len, w_beat_ok, w_beat_err;
    logic [NB-1:0]     ram_we;

    always_comb begin
        w_hs       = s.wvalid && s.wready;
        w_off      = w_addr - BASE;
        w_at_len   = (w_cnt == {1'b0, w_len});
        w_beat_ok  = (w_addr >= BASE) && ((w_off >> AL) < DEPTH) &&
                     (w_burst != BURST_WRAP) && (w_cnt <= {1'b0, w_len});
        w_beat_err = !w_beat_ok || (s.wlast != w_at_len);
        ram_we     = (w_hs && w_beat_ok) ? s.wstrb : '0;
    end

    assign s.awready = alive && (w_state == W_IDLE);
    assign s.wready  = alive && (w_state == W_DATA);
    assign s.bvalid  = alive && (w_state == W_RESP);
    assign s.bresp   = (s.bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
    assign s.bid     = w_id;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: if (s.awvalid && s.awready) begin
                    w_id    <= s.awid;
                    w_addr  <= align_addr(s.awaddr, NB);
                    w_len   <= s.awlen;
                    w_burst <= s.awburst;
                    w_cnt   <= '0;
                    w_err   <= 1'b0;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    w_err <= w_err | w_beat_err;
                    // Saturate so beats past len keep reading as out of bounds.
                    if (w_cnt != 5'h1f) w_cnt <= w_cnt + 5'd1;
                    if (w_burst == BURST_INCR) w_addr <= w_addr + 32'(NB);
                    if (s.wlast) w_state <= W_RESP;
                end
                W_RESP: if (s.bready) begin
                    w_state <= W_IDLE;
                    w_err   <= 1'b0;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    r_state_e          r_state;
    logic [IWIDTH-1:0] r_id;
    logic [31:0]       r_addr, r_off;
    logic [3:0]        r_len, r_cnt;
    logic [1:0]        r_burst;
    logic              r_done, r_issue, r_pop, r_beat_ok;
    logic              s1_valid, s1_ok, s1_last;
    logic [2:0]        r_occ;
    logic [DWIDTH-1:0] ram_rdata, push_data;
    logic [DWIDTH-1:0] f_data [2];
    logic [1:0]        f_resp [2];
    logic              f_last [2];
    logic [1:0]        f_cnt;

    always_comb begin
        r_off     = r_addr - BASE;
        r_beat_ok = (r_addr >= BASE) && ((r_off >> AL) < DEPTH) && (r_burst != BURST_WRAP);
        r_pop     = s.rvalid && s.rready;
        // A new read may issue only if the skid buffer can absorb it when it lands.
        r_occ     = {1'b0, f_cnt} + {2'b0, s1_valid} - {2'b0, r_pop};
        r_issue   = (r_state == R_BURST) && !r_done && (r_occ < 3'd2);
        push_data = s1_ok ? ram_rdata : '0;
    end

    assign s.arready = alive && (r_state == R_IDLE);
    assign s.rvalid  = (f_cnt != 2'd0);
    assign s.rdata   = f_data[0];
    assign s.rresp   = s.rvalid ? f_resp[0] : RESP_OKAY;
    assign s.rlast   = s.rvalid && f_last[0];
    assign s.rid     = r_id;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= R_IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            s1_valid <= 1'b0;
            s1_ok    <= 1'b0;
            s1_last  <= 1'b0;
            f_cnt    <= '0;
            f_resp   <= '{RESP_OKAY, RESP_OKAY};
            f_last   <= '{1'b0, 1'b0};
        end else begin
            unique case (r_state)
                R_IDLE: if (s.arvalid && s.arready) begin
                    r_id    <= s.arid;
                    r_addr  <= align_addr(s.araddr, NB);
                    r_len   <= s.arlen;
                    r_burst <= s.arburst;
                    r_cnt   <= '0;
                    r_done  <= 1'b0;
                    r_state <= R_BURST;
                end
                R_BURST: begin
                    if (r_issue) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == r_len) r_done <= 1'b1;
                        if (r_burst == BURST_INCR) r_addr <= r_addr + 32'(NB);
                    end
                    if (r_pop && s.rlast) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase

            s1_valid <= r_issue;
            s1_ok    <= r_beat_ok;
            s1_last  <= (r_cnt == r_len);

            case ({s1_valid, r_pop})
                2'b10: begin
                    if (f_cnt == 2'd0) begin
                        f_data[0] <= push_data;
                        f_resp[0] <= s1_ok ? RESP_OKAY : RESP_SLVERR;
                        f_last[0] <= s1_last;
                    end else begin
                        f_data[1] <= push_data;
                        f_resp[1] <= s1_ok ? RESP_OKAY : RESP_SLVERR;
                        f_last[1] <= s1_last;
                    end
                    f_cnt <= f_cnt + 2'd1;
                end
                2'b01: begin
                    f_data[0] <= f_data[1];
                    f_resp[0] <= f_resp[1];
                    f_last[0] <= f_last[1];
                    f_cnt     <= f_cnt - 2'd1;
                end
                2'b11: begin
                    if (f_cnt == 2'd1) begin
                        f_data[0] <= push_data;
                        f_resp[0] <= s1_ok ? RESP_OKAY : RESP_SLVERR;
                        f_last[0] <= s1_last;
                    end else begin
                        f_data[0] <= f_data[1];
                        f_resp[0] <= f_resp[1];
                        f_last[0] <= f_last[1];
                        f_data[1] <= push_data;
                        f_resp[1] <= s1_ok ? RESP_OKAY : RESP_SLVERR;
                        f_last[1] <= s1_last;
                    end
                end
                default: ;
            endcase
        end
    end

    sram_dp_bytewe #(
        .DWIDTH(DWIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(w_off[AL +: AW]),
        .wdata(s.wdata),
        .re   (r_issue),
        .raddr(r_off[AL +: AW]),
        .rdata(ram_rdata)
    );

    logic unused_size;
    assign unused_size = ^{s.awsize, s.arsize};

endmodule
